// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerator compute engine: operation codes,
// ternary weight codes, FSM states and default geometry.
package accel_pkg;

    typedef enum logic [1:0] {
        COMP_ADD  = 2'd0,
        COMP_MUL  = 2'd1,
        COMP_TANH = 2'd2,
        COMP_RELU = 2'd3
    } comp_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DONE
    } sce_state_e;

    // Ternary weight codes: bit0 = nonzero, bit1 = negative; 2'b10 decodes as zero.
    localparam logic [1:0] TERN_ZERO = 2'b00;
    localparam logic [1:0] TERN_POS  = 2'b01;
    localparam logic [1:0] TERN_NEG  = 2'b11;

    localparam int DEFAULT_NUM_UNITS = 4;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_FRAC_BITS = 16;

endpackage

// File: rtl/shared_compute_engine_if.sv
// Requester-side bus of the shared compute engine: request/grant handshake,
// operand vectors and the shared result bus.
interface shared_compute_engine_if
    import accel_pkg::*;
#(
    parameter int NUM_UNITS = DEFAULT_NUM_UNITS,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH
);
    localparam int IDW = $clog2(NUM_UNITS);

    logic [NUM_UNITS-1:0]              req;
    logic [NUM_UNITS-1:0]              gnt;
    comp_type_e                        comp_type;
    logic [DEPTH-1:0][WIDTH-1:0]       vec_in;
    logic [DEPTH-1:0][DEPTH-1:0][1:0]  mat_in;
    logic                              busy;
    logic                              done;
    logic [IDW-1:0]                    done_id;
    logic [DEPTH-1:0][WIDTH-1:0]       result;

    modport master (
        output req, comp_type, vec_in, mat_in,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, comp_type, vec_in, mat_in,
        output gnt, busy, done, done_id, result
    );

endinterface

// File: rtl/sce_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer, pointer moves
// past the winner only when a grant is actually taken.
module sce_rr_arbiter #(
    parameter int NUM_UNITS = 4,
    localparam int IDW = $clog2(NUM_UNITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_UNITS-1:0] req_i,
    input  logic                 advance_i,
    output logic [NUM_UNITS-1:0] grant_o,
    output logic [IDW-1:0]       idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] cand;
    logic           found;
    int             c;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        c       = 0;
        for (int off = 0; off < NUM_UNITS; off++) begin
            c = int'(ptr_q) + off;
            if (c >= NUM_UNITS) c = c - NUM_UNITS;
            cand = IDW'(c);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_i && found) begin
            ptr_q <= (idx_o == IDW'(NUM_UNITS - 1)) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/shared_compute_engine.sv
// Shared ternary mat-vec / add / hard-tanh / ReLU engine, one output row per cycle.
// Define SCE_SATURATE_EN to clamp MUL/ADD rows instead of wrapping them.
module shared_compute_engine
    import accel_pkg::*;
#(
    parameter int NUM_UNITS = DEFAULT_NUM_UNITS,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input logic                    clk,
    input logic                    rst_n,
    shared_compute_engine_if.slave bus
);

    localparam int IDW  = $clog2(NUM_UNITS);
    localparam int RW   = $clog2(DEPTH);
    localparam int ACCW = WIDTH + RW + 1;

    typedef logic [DEPTH-1:0][WIDTH-1:0]      vec_t;
    typedef logic [DEPTH-1:0][DEPTH-1:0][1:0] mat_t;
    typedef logic signed [ACCW-1:0]           acc_t;
    typedef logic signed [WIDTH-1:0]          elem_t;

    localparam acc_t  ONE_ACC  = acc_t'(1) << FRAC_BITS;
    localparam elem_t ONE_W    = elem_t'(1) << FRAC_BITS;
    localparam elem_t NEG_ONE_W = -ONE_W;

    sce_state_e           state_q, state_d;
    logic [NUM_UNITS-1:0] gnt_q;
    logic [IDW-1:0]       id_q, done_id_q;
    comp_type_e           op_q;
    vec_t                 x_q, result_q;
    mat_t                 w_q;
    logic [RW-1:0]        row_q;

    logic [NUM_UNITS-1:0] arb_grant;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_advance;
    logic                 last_row;

    acc_t                 acc;
    elem_t                xi;
    logic [WIDTH-1:0]     row_val;
    logic [1:0]           code;
    logic [RW-1:0]        col;

    function automatic acc_t sext(input logic [WIDTH-1:0] v);
        return {{(ACCW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] reduce(input acc_t a);
`ifdef SCE_SATURATE_EN
        if (a > acc_t'({{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}}))
            return {1'b0, {(WIDTH-1){1'b1}}};
        if (a < acc_t'({{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}}))
            return {1'b1, {(WIDTH-1){1'b0}}};
        return a[WIDTH-1:0];
`else
        return a[WIDTH-1:0];
`endif
    endfunction

    assign arb_advance = (state_q == ST_IDLE);
    assign last_row    = (row_q == RW'(DEPTH - 1));

    sce_rr_arbiter #(.NUM_UNITS(NUM_UNITS)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (bus.req),
        .advance_i (arb_advance),
        .grant_o   (arb_grant),
        .idx_o     (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|bus.req) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_COMPUTE;
            ST_COMPUTE: if (last_row) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.gnt     = (state_q == ST_LOAD) ? gnt_q : '0;
        bus.busy    = (state_q == ST_LOAD) || (state_q == ST_COMPUTE);
        bus.done    = (state_q == ST_DONE);
        bus.done_id = done_id_q;
        bus.result  = result_q;
    end

    // Row datapath: MUL/ADD accumulate wide then reduce; TANH/RELU never overflow.
    always_comb begin
        acc     = '0;
        code    = TERN_ZERO;
        col     = '0;
        xi      = elem_t'(x_q[row_q]);
        row_val = x_q[row_q];
        case (op_q)
            COMP_MUL: begin
                for (int j = 0; j < DEPTH; j++) begin
                    col  = RW'(j);
                    code = w_q[row_q][col];
                    if (code == TERN_POS)      acc = acc + sext(x_q[col]);
                    else if (code == TERN_NEG) acc = acc - sext(x_q[col]);
                end
                row_val = reduce(acc);
            end
            COMP_ADD: begin
                code = w_q[row_q][0];
                acc  = sext(x_q[row_q]);
                if (code == TERN_POS)      acc = acc + ONE_ACC;
                else if (code == TERN_NEG) acc = acc - ONE_ACC;
                row_val = reduce(acc);
            end
            COMP_TANH: begin
                if (xi > ONE_W)          row_val = ONE_W;
                else if (xi < NEG_ONE_W) row_val = NEG_ONE_W;
            end
            COMP_RELU: begin
                if (xi[WIDTH-1]) row_val = '0;
            end
            default: row_val = x_q[row_q];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            id_q      <= '0;
            done_id_q <= '0;
            op_q      <= COMP_ADD;
            x_q       <= '0;
            w_q       <= '0;
            row_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (|bus.req) begin
                    gnt_q <= arb_grant;
                    id_q  <= arb_idx;
                end
                ST_LOAD: begin
                    op_q  <= bus.comp_type;
                    x_q   <= bus.vec_in;
                    w_q   <= bus.mat_in;
                    row_q <= '0;
                end
                ST_COMPUTE: begin
                    result_q[row_q] <= row_val;
                    row_q           <= row_q + 1'b1;
                    if (last_row) done_id_q <= id_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_compute_engine.sv
// Self-checking bench for shared_compute_engine: a cycle-level reference model built
// from the timing and arithmetic rules, plus directed literal checks and random traffic.
module tb_shared_compute_engine;
    import accel_pkg::*;

    localparam int NU    = 4;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;
    localparam int FRAC  = 16;
    localparam int IDW   = 2;
    localparam longint ONE  = 64'sd1 << FRAC;
    localparam longint MAXV = (64'sd1 <<< (WIDTH - 1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (WIDTH - 1));

    typedef logic [DEPTH-1:0][WIDTH-1:0]      vec_t;
    typedef logic [DEPTH-1:0][DEPTH-1:0][1:0] mat_t;

    logic clk = 1'b0;
    logic rst_n;

    shared_compute_engine_if #(.NUM_UNITS(NU), .DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

    shared_compute_engine #(
        .NUM_UNITS(NU), .DEPTH(DEPTH), .WIDTH(WIDTH), .FRAC_BITS(FRAC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Per-requester operands; the granted unit's operands are presented on the bus.
    comp_type_e unitOp  [NU];
    vec_t       unitVec [NU];
    mat_t       unitMat [NU];

    function automatic int onehotIdx(input logic [NU-1:0] g);
        for (int i = 0; i < NU; i++) if (g[i]) return i;
        return 0;
    endfunction

    assign bus.comp_type = unitOp[onehotIdx(bus.gnt)];
    assign bus.vec_in    = unitVec[onehotIdx(bus.gnt)];
    assign bus.mat_in    = unitMat[onehotIdx(bus.gnt)];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit               mActive = 0;
    int               mStart  = 0;
    int               mWinner = 0;
    int               mPtr    = 0;
    vec_t             mPending = '0;
    vec_t             mResult  = '0;
    logic [IDW-1:0]   mDoneId  = '0;

    function automatic longint wval(input logic [1:0] c);
        return c[0] ? (c[1] ? -64'sd1 : 64'sd1) : 64'sd0;
    endfunction

    function automatic logic [WIDTH-1:0] reduceW(input longint v);
        longint r;
        r = v;
`ifdef SCE_SATURATE_EN
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
`endif
        return r[WIDTH-1:0];
    endfunction

    function automatic vec_t modelOp(input comp_type_e op, input vec_t x, input mat_t m);
        vec_t   y;
        longint v, xi;
        for (int i = 0; i < DEPTH; i++) begin
            xi = longint'($signed(x[i]));
            case (op)
                COMP_MUL: begin
                    v = 0;
                    for (int j = 0; j < DEPTH; j++) v += wval(m[i][j]) * longint'($signed(x[j]));
                    y[i] = reduceW(v);
                end
                COMP_ADD:  y[i] = reduceW(xi + wval(m[i][0]) * ONE);
                COMP_TANH: begin
                    v = (xi > ONE) ? ONE : ((xi < -ONE) ? -ONE : xi);
                    y[i] = v[WIDTH-1:0];
                end
                default: begin
                    v = (xi < 0) ? 64'sd0 : xi;
                    y[i] = v[WIDTH-1:0];
                end
            endcase
        end
        return y;
    endfunction

    task automatic expectEq(input string name, input logic [DEPTH*WIDTH-1:0] act,
                            input logic [DEPTH*WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, run at the falling edge.
    task automatic checkOutput();
        logic [NU-1:0] expGnt;
        bit            expBusy, expDone, inCompute, found;
        int            c;
        cyc++;
        if (!rst_n) begin
            mActive = 0; mPtr = 0; mResult = '0; mDoneId = '0;
            expectEq("rst_gnt", bus.gnt, 0);
            expectEq("rst_busy", bus.busy, 0);
            expectEq("rst_done", bus.done, 0);
            expectEq("rst_done_id", bus.done_id, 0);
            expectEq("rst_result", bus.result, 0);
            return;
        end
        expGnt  = '0;
        if (mActive && cyc == mStart + 1) expGnt[mWinner] = 1'b1;
        expBusy = mActive && cyc >= mStart + 1 && cyc <= mStart + DEPTH + 1;
        expDone = mActive && cyc == mStart + DEPTH + 2;
        if (expDone) begin
            mResult = mPending;
            mDoneId = IDW'(mWinner);
        end
        expectEq("gnt", bus.gnt, expGnt);
        expectEq("busy", bus.busy, expBusy);
        expectEq("done", bus.done, expDone);
        expectEq("done_id", bus.done_id, mDoneId);
        inCompute = mActive && cyc >= mStart + 2 && cyc <= mStart + DEPTH + 1;
        if (!inCompute) expectEq("result", bus.result, mResult);
        if (mActive && cyc >= mStart + DEPTH + 3) mActive = 0;
        if (!mActive && (|bus.req)) begin
            found = 0;
            for (int o = 0; o < NU; o++) begin
                c = (mPtr + o) % NU;
                if (!found && bus.req[c]) begin
                    found = 1;
                    mWinner = c;
                end
            end
            mActive  = 1;
            mStart   = cyc;
            mPtr     = (mWinner + 1) % NU;
            mPending = modelOp(unitOp[mWinner], unitVec[mWinner], unitMat[mWinner]);
        end
    endtask

    // One clock: compare at the falling edge, then step past the rising edge; a
    // requester drops its req once it sees its grant.
    task automatic tick();
        @(negedge clk);
        checkOutput();
        @(posedge clk);
        #2;
        for (int k = 0; k < NU; k++) if (bus.gnt[k]) bus.req[k] = 1'b0;
    endtask

    task automatic applyStimulus(input int unit, input comp_type_e op, input vec_t v, input mat_t m);
        unitOp[unit]  = op;
        unitVec[unit] = v;
        unitMat[unit] = m;
        bus.req[unit] = 1'b1;
    endtask

    task automatic waitIdle(input string name);
        bit ok;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (bus.req == '0 && !bus.busy && !bus.done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) expectEq({name, "_idle_timeout"}, 1, 0);
    endtask

    function automatic vec_t randVec();
        vec_t v;
        for (int i = 0; i < DEPTH; i++) begin
            if ($urandom_range(0, 3) == 0) v[i] = $urandom;
            else v[i] = 32'($urandom_range(0, 262143)) - 32'd131072;
        end
        return v;
    endfunction

    function automatic mat_t randMat();
        mat_t m;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++) m[i][j] = 2'($urandom_range(0, 3));
        return m;
    endfunction

    vec_t x, expV;
    mat_t m;
    int   gntAt, doneAt, nGrants;
    int   gIdx[$];
    int   gCyc[$];

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        for (int k = 0; k < NU; k++) begin
            unitOp[k]  = comp_type_e'($urandom_range(0, 3));
            unitVec[k] = randVec();
            unitMat[k] = randMat();
        end

        // Contention: every unit requesting from reset
        bus.req = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 60 && gIdx.size() < 4; n++) begin
            tick();
            if (bus.gnt != '0) begin
                gIdx.push_back(onehotIdx(bus.gnt));
                gCyc.push_back(cyc);
            end
        end
        expectEq("contention_grant_count", gIdx.size(), 4);
        for (int i = 0; i < gIdx.size(); i++) begin
            expectEq($sformatf("contention_order_%0d", i), gIdx[i], i);
            if (i > 0) expectEq($sformatf("contention_spacing_%0d", i), gCyc[i] - gCyc[i-1], DEPTH + 3);
        end
        waitIdle("contention");

        // Pointer sits after unit 3: units 1 and 0 together go to 0
        applyStimulus(1, COMP_RELU, randVec(), randMat());
        applyStimulus(0, COMP_TANH, randVec(), randMat());
        tick();
        expectEq("wrap_grant_0", bus.gnt, 4'b0001);
        waitIdle("wrap");

        // Directed MUL on unit 2
        x = '0; m = '0;
        x[0] = 32'd1; x[1] = 32'd2; x[2] = 32'd3; x[3] = 32'd4;
        for (int j = 0; j < DEPTH; j++) begin m[0][j] = 2'b01; m[1][j] = 2'b11; end
        m[2][0] = 2'b01; m[2][2] = 2'b11;
        expV[0] = 32'd10; expV[1] = -32'sd10; expV[2] = -32'sd2; expV[3] = 32'd0;
        expectEq("model_mul_pin", modelOp(COMP_MUL, x, m), expV);
        applyStimulus(2, COMP_MUL, x, m);
        gntAt = -1; doneAt = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus.gnt[2] && gntAt < 0) gntAt = n;
            if (bus.done) begin doneAt = n; break; end
        end
        expectEq("mul_gnt_latency", gntAt, 1);
        expectEq("mul_done_latency", doneAt, 6);
        expectEq("mul_result", bus.result, expV);
        expectEq("mul_done_id", bus.done_id, 2);
        waitIdle("mul");

        // Overflow: rows summing to +2^32 and -2^32
        for (int i = 0; i < DEPTH; i++) x[i] = 32'h4000_0000;
        m = '0;
        for (int j = 0; j < DEPTH; j++) begin m[0][j] = 2'b01; m[1][j] = 2'b11; end
        m[2][0] = 2'b01; m[2][1] = 2'b11; m[2][3] = 2'b10;
`ifdef SCE_SATURATE_EN
        expV[0] = 32'h7FFF_FFFF; expV[1] = 32'h8000_0000;
`else
        expV[0] = 32'h0; expV[1] = 32'h0;
`endif
        expV[2] = 32'h0; expV[3] = 32'h0;
        expectEq("model_sat_pin", modelOp(COMP_MUL, x, m), expV);
        applyStimulus(1, COMP_MUL, x, m);
        for (int n = 0; n < 20 && !bus.done; n++) tick();
        expectEq("sat_result", bus.result, expV);
        waitIdle("sat");

        // ADD, including the 2'b10 code treated as zero
        x[0] = 32'd5; x[1] = 32'd0; x[2] = -32'sd1; x[3] = 32'd0;
        m = '0; m[0][0] = 2'b01; m[1][0] = 2'b11; m[2][0] = 2'b10;
        expV[0] = 32'h0001_0005; expV[1] = 32'hFFFF_0000; expV[2] = 32'hFFFF_FFFF; expV[3] = 32'h0;
        expectEq("model_add_pin", modelOp(COMP_ADD, x, m), expV);
        applyStimulus(3, COMP_ADD, x, m);
        for (int n = 0; n < 20 && !bus.done; n++) tick();
        expectEq("add_result", bus.result, expV);
        waitIdle("add");

        // Hard-tanh and ReLU
        x[0] = 32'h0003_0000; x[1] = -32'sh8000; x[2] = -32'sh30000; x[3] = 32'd0;
        expV[0] = 32'h0001_0000; expV[1] = -32'sh8000; expV[2] = -32'sh10000; expV[3] = 32'd0;
        expectEq("model_tanh_pin", modelOp(COMP_TANH, x, randMat()), expV);
        applyStimulus(0, COMP_TANH, x, randMat());
        for (int n = 0; n < 20 && !bus.done; n++) tick();
        expectEq("tanh_result", bus.result, expV);
        waitIdle("tanh");
        expV = '0; expV[0] = 32'h0003_0000;
        applyStimulus(1, COMP_RELU, x, randMat());
        for (int n = 0; n < 20 && !bus.done; n++) tick();
        expectEq("relu_result", bus.result, expV);
        waitIdle("relu");

        // Reset in the third COMPUTE cycle of a unit-1 operation
        for (int i = 0; i < DEPTH; i++) x[i] = 32'd1;
        m = '0;
        for (int i = 0; i < DEPTH; i++) for (int j = 0; j < DEPTH; j++) m[i][j] = 2'b01;
        applyStimulus(1, COMP_MUL, x, m);
        repeat (4) tick();
        expectEq("pre_reset_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        expectEq("async_busy", bus.busy, 0);
        expectEq("async_done", bus.done, 0);
        expectEq("async_result", bus.result, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        applyStimulus(3, COMP_RELU, randVec(), randMat());
        applyStimulus(0, COMP_RELU, randVec(), randMat());
        tick();
        expectEq("post_reset_grant_0", bus.gnt, 4'b0001);
        waitIdle("post_reset");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NU; k++)
                if (!bus.req[k] && !bus.gnt[k] && $urandom_range(0, 9) == 0)
                    applyStimulus(k, comp_type_e'($urandom_range(0, 3)), randVec(), randMat());
            tick();
        end
        waitIdle("random");
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_compute_engine.md
# shared_compute_engine

Parametrised successor to the single-requester compute unit: one engine shared by `NUM_UNITS` requesters via a registered round-robin arbiter. A granted operation is captured into internal buffers and processed one output row per cycle. Supported operations are ternary-weight mat-vec, vector add, hard-tanh and ReLU. Arithmetic is signed, with optional saturation. Sits between the layer sequencers (requesters) and the shared result bus of the accelerator.

## Interface
- `NUM_UNITS`, 4: number of requesters (2..8).
- `DEPTH`, 16: vector length and matrix dimension (power of two, ≥2).
- `WIDTH`, 32: signed element width.
- `FRAC_BITS`, 16: fixed-point fraction bits; ONE = 1<<FRAC_BITS.
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NUM_UNITS: per-requester request level; held until matching `gnt`.
- `gnt` out NUM_UNITS: one-hot, one-cycle grant (LOAD state).
- `comp_type` in 2 (`comp_type_e`): operation, driven by granted unit; sampled in the `gnt` cycle.
- `vec_in` in DEPTH×WIDTH: signed input vector, sampled in the `gnt` cycle.
- `mat_in` in DEPTH×DEPTH×2: ternary weights, sampled in the `gnt` cycle.
  - bit0 = nonzero; bit1 = negative.
  - ADD uses column 0 bits as addend codes {0,+1,−1}.
- `busy` out 1: high from LOAD through COMPUTE.
- `done` out 1: one-cycle completion pulse.
- `done_id` out clog2(NUM_UNITS): index of the finished requester; valid with `done`, held after.
- `result` out DEPTH×WIDTH: result vector; stable from `done` until the first COMPUTE cycle of the next operation.

## Operation
- FSM states and transitions:
  - IDLE → LOAD when any `req` is high; the arbiter picks a winner.
  - LOAD asserts `gnt[k]` and captures `comp_type`, `vec_in` and `mat_in`.
  - COMPUTE runs `DEPTH` cycles and writes row i in cycle i.
  - DONE asserts `done`, then returns to IDLE.
- Round robin:
  - Search starts at (last granted + 1) mod NUM_UNITS.
  - After reset the pointer selects unit 0 first.
  - The pointer updates only on grant.
- Only `req` seen in IDLE is arbitrated. A `req` dropped before `gnt` is not served. `req` from the granted unit is ignored in LOAD/COMPUTE/DONE; it must drop after `gnt` or it is re-arbitrated.
- Row i per operation (x = captured vector, w = ternary code as −1/0/+1):
  - MUL: y[i] = Σ_j w[i][j]·x[j].
  - ADD: y[i] = x[i] + w[i][0]·ONE.
  - TANH: y[i] = clamp(x[i], −ONE, +ONE).
  - RELU: y[i] = x[i] < 0 ? 0 : x[i].
- Width rules:
  - Accumulate in WIDTH+clog2(DEPTH)+1 bits, then reduce to WIDTH (see Configuration).
  - Weight code 2'b10 (negative, not enabled) is treated as 0.

## Timing
- Reset values:
  - `gnt` = 0, `busy` = 0, `done` = 0, `done_id` = 0, `result` = all 0.
  - FSM in IDLE; RR pointer targets unit 0.
- A `req` high in idle cycle T produces:
  - `gnt` at T+1.
  - Rows 0..DEPTH−1 written at T+2..T+1+DEPTH.
  - `done` at T+2+DEPTH.
  - Next IDLE at T+3+DEPTH.
- Latency is req→done = DEPTH+2 cycles; throughput is one operation per DEPTH+3 cycles.
- Simultaneous requests: exactly one grant per arbitration; losers keep `req` high and are served in RR order.
- Reset mid-operation:
  - Immediate return to reset values; captured data is discarded.
  - No `done` is issued for the aborted operation.
- `result` rows of an in-flight operation are visible as written; consumers must sample only on `done`.

## Configuration
- `SCE_SATURATE_EN` defined: each row result clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- `SCE_SATURATE_EN` undefined: the row result keeps the low WIDTH bits (two's-complement wrap).
- TANH and RELU are unaffected by the macro.

## Structure
- `accel_pkg` holds `comp_type_e` (COMP_ADD=0, COMP_MUL=1, COMP_TANH=2, COMP_RELU=3), ternary code constants and default DEPTH/WIDTH/FRAC_BITS constants.
- Vector and matrix types are module-local, sized by parameters.
- Sub-module `sce_rr_arbiter`:
  - Parameter NUM_UNITS.
  - Inputs `req`, `advance`; outputs one-hot `grant` and index.
  - Owns the RR pointer.

## Test plan
- Single MUL, unit 2, DEPTH=4, x={1,2,3,4}:
  - Stimulus: row0 = all +1, row1 = all −1, row2 = {+1,0,−1,0}, row3 = all 0.
  - Expected: `result` = {10,−10,−2,0}; `gnt[2]` at T+1, `done` at T+6, `done_id` = 2.
- Contention, all four `req` high from reset, held until each grant:
  - Grants in order 0,1,2,3, each spaced DEPTH+3 cycles.
  - Then a new req from 1 and 0 together: grant goes to 0 (pointer after 3).
- Saturation, WIDTH=8, MUL with x = all 100 and row0 = all +1 (DEPTH=4):
  - With `SCE_SATURATE_EN`: y0 = 127.
  - Without it: y0 = 400 mod 256 = −112 (0x90).
- TANH/RELU, FRAC_BITS=16, x = {0x30000, −0x8000, −0x30000, 0}:
  - TANH = {0x10000, −0x8000, −0x10000, 0}.
  - RELU = {0x30000, 0, 0, 0}.
- Reset asserted at the 3rd COMPUTE cycle:
  - `busy`/`done`/`result` return to 0 asynchronously.
  - No `done` follows; the next req is granted normally with the pointer back at unit 0.
